// File: rtl/mm2s_burst_scheduler.sv
// mm2s_burst_scheduler: splits a linear read command into 4 KiB-safe AXI4 INCR bursts for the read channel
module mm2s_burst_scheduler #(
  parameter int DMA_DATA_WIDTH_SRC = 64,
  parameter int DMA_AXI_ADDR_WIDTH = 32,
  parameter int CMD_LEN_WIDTH = 24,
  parameter int MAX_BURST_BEATS = 256
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [CMD_LEN_WIDTH-1:0]      cmd_bytes_i,
  input  logic                          abort_i,
  output logic                          read_start_o,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] read_addr_o,
  output logic [7:0]                    read_len_o,
  output logic [2:0]                    read_size_o,
  input  logic                          read_busy_i,
  output logic                          done_o,
  output logic                          cmd_err_o,
  output logic                          aborted_o,
  output logic [15:0]                   burst_cnt_o
);
  localparam int BEAT_BYTES = DMA_DATA_WIDTH_SRC / 8;
  localparam int SIZE = $clog2(BEAT_BYTES);
  localparam logic [DMA_AXI_ADDR_WIDTH-1:0] AMASK = DMA_AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
  localparam logic [CMD_LEN_WIDTH-1:0] CMASK = CMD_LEN_WIDTH'(BEAT_BYTES - 1);
  typedef enum logic [2:0] {IDLE, CALC, START, WAIT_ACK, WAIT_DONE} state_t;
  state_t state;
  logic [DMA_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [CMD_LEN_WIDTH-1:0] rem_beats;
  logic [8:0] beats_q;
  logic [12:0] to4k;
  logic [12:0] lim;
  logic [8:0] beats;
  assign cmd_ready_o = state == IDLE;
  assign read_size_o = 3'(SIZE);
  // beats for the next burst: remaining work capped by burst limit and distance to the 4 KiB page end
  always_comb begin
    to4k = (13'd4096 - {1'b0, cur_addr[11:0]}) >> SIZE;
    lim = (to4k < 13'(MAX_BURST_BEATS)) ? to4k : 13'(MAX_BURST_BEATS);
    beats = (32'(rem_beats) < 32'(lim)) ? 9'(rem_beats) : 9'(lim);
  end
  // command acceptance and burst sequencing with registered outputs
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state <= IDLE;
      read_start_o <= 1'b0;
      done_o <= 1'b0;
      cmd_err_o <= 1'b0;
      aborted_o <= 1'b0;
      burst_cnt_o <= '0;
      read_addr_o <= '0;
      read_len_o <= '0;
      cur_addr <= '0;
      rem_beats <= '0;
      beats_q <= '0;
    end else begin
      read_start_o <= 1'b0;
      done_o <= 1'b0;
      cmd_err_o <= 1'b0;
      case (state)
        IDLE: if (cmd_valid_i) begin
          aborted_o <= 1'b0;
          burst_cnt_o <= '0;
          if (|(cmd_addr_i & AMASK) || |(cmd_bytes_i & CMASK)) cmd_err_o <= 1'b1;
          else if (cmd_bytes_i == '0) done_o <= 1'b1;
          else begin
            rem_beats <= cmd_bytes_i >> SIZE;
            cur_addr <= cmd_addr_i;
            state <= CALC;
          end
        end
        CALC: begin
          read_addr_o <= cur_addr;
          read_len_o <= 8'(beats - 9'd1);
          beats_q <= beats;
          state <= START;
        end
        START: begin
          read_start_o <= 1'b1;
          if (~&burst_cnt_o) burst_cnt_o <= burst_cnt_o + 16'd1;
          cur_addr <= cur_addr + (DMA_AXI_ADDR_WIDTH'(beats_q) << SIZE);
          rem_beats <= rem_beats - CMD_LEN_WIDTH'(beats_q);
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (read_busy_i) state <= WAIT_DONE;
        WAIT_DONE: if (!read_busy_i) begin
          if (rem_beats == '0) begin
            done_o <= 1'b1;
            state <= IDLE;
          end else if (abort_i) begin
            done_o <= 1'b1;
            aborted_o <= 1'b1;
            state <= IDLE;
          end else state <= CALC;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm2s_burst_scheduler.sv
// tb_mm2s_burst_scheduler: randomized and directed checks of the burst scheduler against an arithmetic burst model
module tb_mm2s_burst_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic abort_in = 1'b0;
  logic busy = 1'b0;
  logic sel = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [23:0] cmd_bytes = '0;
  logic ready_v [2];
  logic start_v [2];
  logic [31:0] raddr_v [2];
  logic [7:0] rlen_v [2];
  logic [2:0] rsize_v [2];
  logic done_v [2];
  logic err_v [2];
  logic abt_v [2];
  logic [15:0] cnt_v [2];
  int total = 0;
  int bad = 0;
  logic [31:0] exp_addr [$];
  int exp_len [$];
  bit exp_ab;
  wire ready = ready_v[sel];
  wire start = start_v[sel];
  wire [31:0] raddr = raddr_v[sel];
  wire [7:0] rlen = rlen_v[sel];
  wire [2:0] rsize = rsize_v[sel];
  wire done = done_v[sel];
  wire err = err_v[sel];
  wire abt = abt_v[sel];
  wire [15:0] cnt = cnt_v[sel];

  always #5 clk = ~clk;

  mm2s_burst_scheduler u0 (
    .m_axi_aclk(clk), .m_axi_areset(rst), .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(ready_v[0]),
    .cmd_addr_i(cmd_addr), .cmd_bytes_i(cmd_bytes), .abort_i(abort_in), .read_start_o(start_v[0]),
    .read_addr_o(raddr_v[0]), .read_len_o(rlen_v[0]), .read_size_o(rsize_v[0]), .read_busy_i(busy & ~sel),
    .done_o(done_v[0]), .cmd_err_o(err_v[0]), .aborted_o(abt_v[0]), .burst_cnt_o(cnt_v[0])
  );

  mm2s_burst_scheduler #(.MAX_BURST_BEATS(16)) u1 (
    .m_axi_aclk(clk), .m_axi_areset(rst), .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(ready_v[1]),
    .cmd_addr_i(cmd_addr), .cmd_bytes_i(cmd_bytes), .abort_i(abort_in), .read_start_o(start_v[1]),
    .read_addr_o(raddr_v[1]), .read_len_o(rlen_v[1]), .read_size_o(rsize_v[1]), .read_busy_i(busy & sel),
    .done_o(done_v[1]), .cmd_err_o(err_v[1]), .aborted_o(abt_v[1]), .burst_cnt_o(cnt_v[1])
  );

  task automatic chk(string tag, longint obs, longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected burst list: walk the byte range, each burst limited by remaining beats, burst cap and page end
  function automatic void model(logic [31:0] a, int bytes, int mbb, bit abrt);
    int rem, to4k, b;
    exp_addr.delete();
    exp_len.delete();
    rem = bytes / 8;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 4096)) / 8;
      b = rem;
      if (b > mbb) b = mbb;
      if (b > to4k) b = to4k;
      exp_addr.push_back(a);
      exp_len.push_back(b - 1);
      a = a + 32'(b * 8);
      rem -= b;
    end
    exp_ab = abrt && exp_addr.size() > 1;
    while (exp_ab && exp_addr.size() > 1) begin
      void'(exp_addr.pop_back());
      void'(exp_len.pop_back());
    end
  endfunction

  task automatic run(bit s, logic [31:0] a, logic [23:0] n, bit abrt);
    bit err_exp = (a % 8 != 0) || (n % 8 != 0);
    int ns = 0, nd = 0, ne = 0, since = 0, hold = 0, cyc = 0;
    bit fin = 0;
    sel = s;
    if (err_exp) begin
      exp_addr.delete();
      exp_len.delete();
      exp_ab = 0;
    end else model(a, int'(n), s ? 16 : 256, abrt);
    @(negedge clk);
    chk("ready_before", ready, 1);
    cmd_addr = a;
    cmd_bytes = n;
    abort_in = abrt;
    cmd_valid = 1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cmd_valid = 0;
      since++;
      cyc++;
      if (start) begin
        if (ns < exp_addr.size()) begin
          chk("burst_addr", raddr, exp_addr[ns]);
          chk("burst_len", rlen, exp_len[ns]);
        end else chk("extra_start", ns, exp_addr.size());
        chk("cnt_at_start", cnt, ns + 1);
        ns++;
        busy = 1;
        hold = $urandom_range(1, 4);
      end else if (busy) begin
        if (hold == 0) begin
          busy = 0;
          since = 0;
        end else hold--;
      end
      if (done) begin
        nd++;
        chk("done_latency", since, 1);
        fin = 1;
      end
      if (err) begin
        ne++;
        fin = 1;
      end
    end
    chk("finished_in_budget", fin, 1);
    repeat (4) begin
      @(negedge clk);
      if (start) ns++;
      if (done) nd++;
      if (err) ne++;
    end
    abort_in = 0;
    busy = 0;
    chk("start_count", ns, exp_addr.size());
    chk("done_count", nd, err_exp ? 0 : 1);
    chk("err_count", ne, err_exp ? 1 : 0);
    chk("aborted", abt, exp_ab);
    chk("burst_cnt_end", cnt, exp_addr.size());
    chk("ready_after", ready, 1);
  endtask

  initial begin
    int ns;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      sel = 1'(i);
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_start", start, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_aborted", abt, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_addr", raddr, 0);
      chk("rst_len", rlen, 0);
      chk("rst_size", rsize, 3);
    end
    run(0, 32'h0000_1000, 24'd4096, 0);
    run(0, 32'h0000_0FF0, 24'd64, 0);
    run(1, 32'h0000_0000, 24'd1024, 0);
    run(0, 32'h0000_1004, 24'd64, 0);
    run(0, 32'h0000_1000, 24'd60, 0);
    run(0, 32'h0000_2000, 24'd0, 0);
    run(0, 32'h0000_1000, 24'd4096, 1);
    run(0, 32'h0000_3000, 24'd64, 1);
    run(0, 32'hFFFF_FFC0, 24'd128, 0);
    sel = 0;
    @(negedge clk);
    cmd_addr = 32'h0000_1000;
    cmd_bytes = 24'd4096;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 20 && !start; i++) @(negedge clk);
    chk("rst_mid_start_seen", start, 1);
    busy = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    busy = 0;
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_cnt", cnt, 0);
    chk("rst_mid_start", start, 0);
    chk("rst_mid_done", done, 0);
    ns = 0;
    repeat (6) begin
      @(negedge clk);
      if (start) ns++;
    end
    chk("rst_mid_no_start", ns, 0);
    run(0, 32'h0000_1000, 24'd4096, 0);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [23:0] n;
      a = $urandom & 32'hFFFF_FFF8;
      n = 24'($urandom_range(0, 700) * 8);
      if ($urandom_range(0, 7) == 0) a = a | 32'h4;
      if ($urandom_range(0, 7) == 0) n = n + 24'd4;
      run(1'($urandom_range(0, 1)), a, n, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
